// File: rtl/ctrl_pipe_n.sv
// ctrl_pipe_n
//   Parametrised control-word pipeline that carries decoded control bundles
//   from decode through the later stages to writeback. Each stage has a valid
//   bit, a control word, a gated regwrite bit and a destination register.
//   Stalls propagate backwards, and bubbles fill the gap behind a frozen
//   stage. Each stage can be flushed on its own. Destination-register hazard
//   match vectors and a registered occupancy count are provided.
//
// Optional feature: define CTRL_PIPE_PERF_EN to add three 32-bit performance
//   counters: perf_retired, perf_bubbles and perf_stall_cycles.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-low reset
//   in_valid       decode presents a bundle
//   in_ready       pipeline accepts the bundle this cycle
//   in_ctrl        decoded control word (CW)
//   in_regwr       bundle writes the register file
//   in_dst         destination register (DSTW)
//   stall          per-stage stall request, bit k = stage k
//   flush          per-stage flush, bit k = stage k
//   q_src_a/b      hazard query source registers
//   stage_valid    valid bit per stage
//   stage_ctrl     control words, stage k at [k*CW +: CW]
//   stage_regwr    gated regwrite per stage
//   stage_dst      destination register per stage, stage k at [k*DSTW +: DSTW]
//   match_a/b      per-stage hazard match against q_src_a / q_src_b
//   occupancy      number of valid stages (registered)
//   retire_valid   last stage holds a valid bundle
module ctrl_pipe_n #(
  parameter int STAGES = 6,
  parameter int CW     = 16,
  parameter int DSTW   = 5,
  parameter int OCCW   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CW-1:0]            in_ctrl,
  input  logic                     in_regwr,
  input  logic [DSTW-1:0]          in_dst,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  input  logic [DSTW-1:0]          q_src_a,
  input  logic [DSTW-1:0]          q_src_b,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*CW-1:0]     stage_ctrl,
  output logic [STAGES-1:0]        stage_regwr,
  output logic [STAGES*DSTW-1:0]   stage_dst,
  output logic [STAGES-1:0]        match_a,
  output logic [STAGES-1:0]        match_b,
  output logic [OCCW-1:0]          occupancy,
  output logic                     retire_valid
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]              perf_retired,
  output logic [31:0]              perf_bubbles,
  output logic [31:0]              perf_stall_cycles
`endif
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] regwr_q, regwr_d;
  logic [CW-1:0]     ctrl_q [STAGES];
  logic [CW-1:0]     ctrl_d [STAGES];
  logic [DSTW-1:0]   dst_q  [STAGES];
  logic [DSTW-1:0]   dst_d  [STAGES];
  logic [STAGES-1:0] hold;
  logic [STAGES-1:0] hold_prev;
  logic [OCCW-1:0]   occ_d;

  // The hold of a stage is the OR of its own stall and every later stall.
  // The loop uses a running accumulator so that hold never reads itself.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc     = acc | stall[k];
      hold[k] = acc;
    end
  end

  // hold_prev[k] is the hold of stage k-1. Stage 0 has no upstream stage in
  // the chain, so its bit is tied to 0.
  assign hold_prev = {hold[STAGES-2:0], 1'b0};
  assign in_ready  = ~hold[0];

  // Next-state selection. Flush beats hold. Stage 0 loads from decode. A
  // stage that moves while its upstream neighbour is frozen takes a bubble.
  // Invalid entries always carry ctrl = 0 and regwr = 0.
  always_comb begin
    valid_d = valid_q;
    regwr_d = regwr_q;
    for (int k = 0; k < STAGES; k++) begin
      ctrl_d[k] = ctrl_q[k];
      dst_d[k]  = dst_q[k];
    end
    for (int k = 0; k < STAGES; k++) begin
      if (flush[k] || (k != 0 && !hold[k] && hold_prev[k])) begin
        valid_d[k] = 1'b0;
        regwr_d[k] = 1'b0;
        ctrl_d[k]  = '0;
        dst_d[k]   = '0;
      end else if (hold[k]) begin
        valid_d[k] = valid_q[k];
      end else if (k == 0) begin
        valid_d[0] = in_valid;
        regwr_d[0] = in_regwr & in_valid;
        ctrl_d[0]  = in_valid ? in_ctrl : '0;
        dst_d[0]   = in_dst;
      end else begin
        valid_d[k] = valid_q[k-1];
        regwr_d[k] = regwr_q[k-1];
        ctrl_d[k]  = ctrl_q[k-1];
        dst_d[k]   = dst_q[k-1];
      end
    end
  end

  // Occupancy is counted from the next-state valid vector, so the registered
  // count changes in the same cycle as the stages it describes.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++)
      occ_d = occ_d + OCCW'(valid_d[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q   <= '0;
      regwr_q   <= '0;
      occupancy <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= '0;
        dst_q[k]  <= '0;
      end
    end else begin
      valid_q   <= valid_d;
      regwr_q   <= regwr_d;
      occupancy <= occ_d;
      for (int k = 0; k < STAGES; k++) begin
        ctrl_q[k] <= ctrl_d[k];
        dst_q[k]  <= dst_d[k];
      end
    end
  end

  // Flatten the stage registers onto the packed output buses. Register 0
  // never produces a hazard match.
  always_comb begin
    stage_ctrl = '0;
    stage_dst  = '0;
    match_a    = '0;
    match_b    = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_ctrl[k*CW +: CW]     = ctrl_q[k];
      stage_dst[k*DSTW +: DSTW]  = dst_q[k];
      match_a[k] = regwr_q[k] && (dst_q[k] == q_src_a) && (q_src_a != '0);
      match_b[k] = regwr_q[k] && (dst_q[k] == q_src_b) && (q_src_b != '0);
    end
  end

  assign stage_valid  = valid_q;
  assign stage_regwr  = regwr_q;
  assign retire_valid = valid_q[STAGES-1];

`ifdef CTRL_PIPE_PERF_EN
  logic [OCCW-1:0] bubble_cnt;

  // This counts the stages that take a bubble at this edge. The flush and
  // hold checks mirror the priority order of the next-state block above.
  always_comb begin
    bubble_cnt = '0;
    for (int k = 1; k < STAGES; k++)
      bubble_cnt = bubble_cnt + OCCW'(!flush[k] && !hold[k] && hold_prev[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_retired      <= '0;
      perf_bubbles      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      perf_retired      <= perf_retired + 32'(retire_valid & ~hold[STAGES-1]);
      perf_bubbles      <= perf_bubbles + 32'(bubble_cnt);
      perf_stall_cycles <= perf_stall_cycles + 32'(~in_ready);
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_n.sv
// tb_ctrl_pipe_n
//   Testbench for ctrl_pipe_n with the default parameters. Retiring control
//   words are checked in order against a queue of the bundles that decode
//   handed over. A table of hazard queries is checked against a frozen, fully
//   loaded pipe. Hand-written sequences cover stalls, flushes and
//   asynchronous reset.
module tb_ctrl_pipe_n;
  localparam int STAGES = 6;
  localparam int CW     = 16;
  localparam int DSTW   = 5;
  localparam int OCCW   = 5;

  logic                   clk;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [CW-1:0]          in_ctrl;
  logic                   in_regwr;
  logic [DSTW-1:0]        in_dst;
  logic [STAGES-1:0]      stall;
  logic [STAGES-1:0]      flush;
  logic [DSTW-1:0]        q_src_a;
  logic [DSTW-1:0]        q_src_b;
  logic [STAGES-1:0]      stage_valid;
  logic [STAGES*CW-1:0]   stage_ctrl;
  logic [STAGES-1:0]      stage_regwr;
  logic [STAGES*DSTW-1:0] stage_dst;
  logic [STAGES-1:0]      match_a;
  logic [STAGES-1:0]      match_b;
  logic [OCCW-1:0]        occupancy;
  logic                   retire_valid;
`ifdef CTRL_PIPE_PERF_EN
  logic [31:0]            perf_retired;
  logic [31:0]            perf_bubbles;
  logic [31:0]            perf_stall_cycles;
`endif

  ctrl_pipe_n #(.STAGES(STAGES), .CW(CW), .DSTW(DSTW), .OCCW(OCCW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_ctrl      (in_ctrl),
    .in_regwr     (in_regwr),
    .in_dst       (in_dst),
    .stall        (stall),
    .flush        (flush),
    .q_src_a      (q_src_a),
    .q_src_b      (q_src_b),
    .stage_valid  (stage_valid),
    .stage_ctrl   (stage_ctrl),
    .stage_regwr  (stage_regwr),
    .stage_dst    (stage_dst),
    .match_a      (match_a),
    .match_b      (match_b),
    .occupancy    (occupancy),
    .retire_valid (retire_valid)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .perf_retired      (perf_retired),
    .perf_bubbles      (perf_bubbles),
    .perf_stall_cycles (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [CW-1:0] sb_q [$];
  bit            sb_en = 1'b0;

  typedef struct {
    logic [DSTW-1:0]   qa;
    logic [DSTW-1:0]   qb;
    logic [STAGES-1:0] ma;
    logic [STAGES-1:0] mb;
  } hz_vec_t;

  hz_vec_t hz_tab [6];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [CW-1:0] c, input logic rw, input logic [DSTW-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_regwr = rw;
    in_dst   = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] get_ctrl(input int k);
    return stage_ctrl[k*CW +: CW];
  endfunction

  function automatic logic [DSTW-1:0] get_dst(input int k);
    return stage_dst[k*DSTW +: DSTW];
  endfunction

  // Scoreboard: pop on retire, then push on accept. Both happen at the
  // falling edge, which is half a cycle away from the edge that moves data.
  always @(negedge clk) begin
    if (reset && sb_en) begin
      if (retire_valid && !stall[STAGES-1]) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_unexpected_retire: got %0h expected none", get_ctrl(STAGES-1));
        end else begin
          checkOutput("sb_retire_ctrl", 32'(get_ctrl(STAGES-1)), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready && !flush[0])
        sb_q.push_back(in_ctrl);
    end
  end

  initial begin
    logic [DSTW-1:0] tdst [6];
    logic            treg [6];
    tdst = '{5'd3, 5'd0, 5'd7, 5'd7, 5'd3, 5'd9};
    treg = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    hz_tab[0] = '{qa: 5'd3,  qb: 5'd0,  ma: 6'b100010, mb: 6'b000000};
    hz_tab[1] = '{qa: 5'd7,  qb: 5'd9,  ma: 6'b000100, mb: 6'b000001};
    hz_tab[2] = '{qa: 5'd0,  qb: 5'd3,  ma: 6'b000000, mb: 6'b100010};
    hz_tab[3] = '{qa: 5'd9,  qb: 5'd12, ma: 6'b000001, mb: 6'b000000};
    hz_tab[4] = '{qa: 5'd12, qb: 5'd7,  ma: 6'b000000, mb: 6'b000100};
    hz_tab[5] = '{qa: 5'd31, qb: 5'd8,  ma: 6'b000000, mb: 6'b000000};

    reset = 1'b0; stall = '0; flush = '0; q_src_a = '0; q_src_b = '0;
    applyStimulus(1'b0, '0, 1'b0, '0);
    repeat (3) tick();
    checkOutput("reset_valid", 32'(stage_valid), 32'h0);
    checkOutput("reset_occ", 32'(occupancy), 32'h0);
    checkOutput("reset_retire", 32'(retire_valid), 32'h0);

    // A single bundle walks the pipe.
    reset = 1'b1;
    sb_en = 1'b1;
    applyStimulus(1'b1, 16'hA5A5, 1'b1, 5'd8);
    checkOutput("ready_after_reset", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("walk_valid_0", 32'(stage_valid), 32'h01);
    checkOutput("walk_occ_0", 32'(occupancy), 32'h1);
    for (int i = 1; i < STAGES; i++) begin
      checkOutput("walk_retire_early", 32'(retire_valid), 32'h0);
      tick();
      checkOutput("walk_valid", 32'(stage_valid), 32'(1 << i));
      checkOutput("walk_occ", 32'(occupancy), 32'h1);
    end
    checkOutput("walk_ctrl5", 32'(get_ctrl(5)), 32'hA5A5);
    checkOutput("walk_dst5", 32'(get_dst(5)), 32'h8);
    checkOutput("walk_regwr5", 32'(stage_regwr), 32'h20);
    checkOutput("walk_retire", 32'(retire_valid), 32'h1);
    tick();
    checkOutput("walk_occ_end", 32'(occupancy), 32'h0);

    // An invalid input enters with ctrl and regwr forced to 0.
    applyStimulus(1'b0, 16'hFFFF, 1'b1, 5'd5);
    tick();
    checkOutput("inv_ctrl0", 32'(get_ctrl(0)), 32'h0);
    checkOutput("inv_regwr", 32'(stage_regwr), 32'h0);
    checkOutput("inv_valid", 32'(stage_valid), 32'h0);

    // Back-to-back bundles 1..8.
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 16'(16'h1000 + i), 1'b1, 5'(i));
      checkOutput("b2b_ready", 32'(in_ready), 32'h1);
      tick();
      checkOutput("b2b_occ", 32'(occupancy), 32'((i < STAGES) ? i : STAGES));
    end
    applyStimulus(1'b0, '0, 1'b0, '0);
    for (int j = 1; j <= STAGES; j++) begin
      tick();
      checkOutput("b2b_drain_occ", 32'(occupancy), 32'(STAGES - j));
    end

    // Fill the pipe, then stall stage 2 for two cycles.
    for (int i = 1; i <= STAGES; i++) begin
      applyStimulus(1'b1, 16'(16'h2000 + i), 1'b1, 5'(i));
      tick();
    end
    checkOutput("st_full_occ", 32'(occupancy), 32'h6);
    stall = 6'b000100;
    applyStimulus(1'b1, 16'h2007, 1'b1, 5'd7);
    checkOutput("st_ready0", 32'(in_ready), 32'h0);
    tick();
    checkOutput("st1_ctrl0", 32'(get_ctrl(0)), 32'h2006);
    checkOutput("st1_ctrl1", 32'(get_ctrl(1)), 32'h2005);
    checkOutput("st1_ctrl2", 32'(get_ctrl(2)), 32'h2004);
    checkOutput("st1_ctrl3", 32'(get_ctrl(3)), 32'h0);
    checkOutput("st1_ctrl4", 32'(get_ctrl(4)), 32'h2003);
    checkOutput("st1_valid", 32'(stage_valid), 32'h37);
    checkOutput("st1_regwr", 32'(stage_regwr), 32'h37);
    checkOutput("st1_occ", 32'(occupancy), 32'h5);
    checkOutput("st1_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("st2_ctrl3", 32'(get_ctrl(3)), 32'h0);
    checkOutput("st2_ctrl4", 32'(get_ctrl(4)), 32'h0);
    checkOutput("st2_ctrl5", 32'(get_ctrl(5)), 32'h2003);
    checkOutput("st2_valid", 32'(stage_valid), 32'h27);
    checkOutput("st2_occ", 32'(occupancy), 32'h4);
    stall = '0;
    #1;
    checkOutput("st_ready_back", 32'(in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0);
    checkOutput("st3_ctrl0", 32'(get_ctrl(0)), 32'h2007);
    checkOutput("st3_ctrl3", 32'(get_ctrl(3)), 32'h2004);
    checkOutput("st3_occ", 32'(occupancy), 32'h4);
    repeat (8) tick();
    checkOutput("sb_empty", 32'(sb_q.size()), 32'h0);
    sb_en = 1'b0;

    // Load a known pattern, freeze it, and run the hazard query table.
    for (int i = 0; i < STAGES; i++) begin
      applyStimulus(1'b1, 16'(16'h3000 + i), treg[i], tdst[i]);
      tick();
    end
    stall = '1;
    applyStimulus(1'b1, 16'hDEAD, 1'b1, 5'd1);
    checkOutput("hz_ready", 32'(in_ready), 32'h0);
    for (int r = 0; r < 6; r++) begin
      q_src_a = hz_tab[r].qa;
      q_src_b = hz_tab[r].qb;
      #1;
      checkOutput("hz_match_a", 32'(match_a), 32'(hz_tab[r].ma));
      checkOutput("hz_match_b", 32'(match_b), 32'(hz_tab[r].mb));
    end
    repeat (2) tick();
    checkOutput("frz_valid", 32'(stage_valid), 32'h3F);
    checkOutput("frz_occ", 32'(occupancy), 32'h6);
    checkOutput("frz_ctrl0", 32'(get_ctrl(0)), 32'h3005);
    checkOutput("frz_ctrl5", 32'(get_ctrl(5)), 32'h3000);

    // Flushing stage 1 beats its hold and clears its match.
    q_src_a = 5'd3;
    q_src_b = 5'd0;
    flush = 6'b000010;
    tick();
    checkOutput("fl1_match_a", 32'(match_a), 32'h20);
    checkOutput("fl1_valid", 32'(stage_valid), 32'h3D);
    checkOutput("fl1_ctrl1", 32'(get_ctrl(1)), 32'h0);
    checkOutput("fl1_occ", 32'(occupancy), 32'h5);

    // Flush and stall stage 0 together: the incoming bundle is dropped and
    // stage 1 takes a bubble.
    stall = 6'b000001;
    flush = 6'b000001;
    applyStimulus(1'b1, 16'hBEEF, 1'b1, 5'd2);
    tick();
    checkOutput("fs0_valid", 32'(stage_valid), 32'h38);
    checkOutput("fs0_ctrl0", 32'(get_ctrl(0)), 32'h0);
    checkOutput("fs0_ctrl1", 32'(get_ctrl(1)), 32'h0);
    checkOutput("fs0_ctrl3", 32'(get_ctrl(3)), 32'h3003);
    checkOutput("fs0_occ", 32'(occupancy), 32'h3);

    // Flushing stage 0 alone leaves in_ready at 1 but drops the bundle.
    stall = '0;
    applyStimulus(1'b1, 16'hCAFE, 1'b1, 5'd4);
    checkOutput("f0_ready", 32'(in_ready), 32'h1);
    tick();
    flush = '0;
    checkOutput("f0_valid", 32'(stage_valid), 32'h30);
    checkOutput("f0_ctrl0", 32'(get_ctrl(0)), 32'h0);
    checkOutput("f0_occ", 32'(occupancy), 32'h2);

    // Reset in the middle of a stream with 5 stages valid.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 16'(16'h4000 + i), 1'b1, 5'(i + 1));
      tick();
    end
    checkOutput("mr_pre_valid", 32'(stage_valid), 32'h1F);
    checkOutput("mr_pre_occ", 32'(occupancy), 32'h5);
    applyStimulus(1'b0, '0, 1'b0, '0);
    reset = 1'b0;
    #1;
    checkOutput("mr_valid", 32'(stage_valid), 32'h0);
    checkOutput("mr_occ", 32'(occupancy), 32'h0);
    checkOutput("mr_retire", 32'(retire_valid), 32'h0);
`ifdef CTRL_PIPE_PERF_EN
    checkOutput("mr_perf_retired", perf_retired, 32'h0);
    checkOutput("mr_perf_bubbles", perf_bubbles, 32'h0);
    checkOutput("mr_perf_stall", perf_stall_cycles, 32'h0);
`endif
    repeat (2) tick();
    reset = 1'b1;
    #1;
    checkOutput("mr_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("mr_post_valid", 32'(stage_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
